// File: rtl/booth_pkg.sv
// Shared definitions for the radix-2 Booth multiplier: controller states,
// legal operand-width range and the iteration-count rule.
package booth_pkg;

    localparam int WIDTH_MIN = 4;
    localparam int WIDTH_MAX = 32;

    // Counter is sized for the widest legal unsigned run (WIDTH_MAX+1 steps).
    localparam int CNT_W = $clog2(WIDTH_MAX + 2);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD_X  = 3'd1,
        COMPUTE = 3'd2,
        OUT_HI  = 3'd3,
        OUT_LO  = 3'd4
    } booth_state_t;

    function automatic logic [CNT_W-1:0] iter_count(input int width, input logic is_signed);
        return is_signed ? CNT_W'(width) : CNT_W'(width + 1);
    endfunction

endpackage

// File: rtl/booth_dp.sv
// Booth datapath: operand/accumulator registers, one shared add/subtract,
// the combined arithmetic right shift and the product output mux.
module booth_dp
    import booth_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cap_y,
    input  logic             cap_x,
    input  logic             step,
    input  logic             show_hi,
    input  logic             show_lo,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] in_bus,
    output logic             mode,
    output logic [WIDTH-1:0] out_bus
);

    logic [WIDTH:0]     a_q;
    logic [WIDTH:0]     x_q;
    logic [WIDTH:0]     y_q;
    logic               xneg1_q;
    logic               mode_q;

    logic [WIDTH:0]     y_ext;
    logic [WIDTH:0]     x_ext;
    logic               use_y;
    logic               sub;
    logic [WIDTH:0]     addsub;
    logic [WIDTH:0]     a_pre;
    logic [2*WIDTH-1:0] product;

    // Y's extension follows the live mode bit because both are captured together.
    assign y_ext = {signed_mode & in_bus[WIDTH-1], in_bus};
    assign x_ext = {mode_q & in_bus[WIDTH-1], in_bus};

    assign use_y  = x_q[0] ^ xneg1_q;
    assign sub    = x_q[0] & ~xneg1_q;
    assign addsub = a_q + (y_q ^ {(WIDTH+1){sub}}) + {{WIDTH{1'b0}}, sub};
    assign a_pre  = use_y ? addsub : a_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q     <= '0;
            x_q     <= '0;
            y_q     <= '0;
            xneg1_q <= 1'b0;
            mode_q  <= 1'b0;
        end else if (cap_y) begin
            y_q    <= y_ext;
            mode_q <= signed_mode;
        end else if (cap_x) begin
            x_q     <= x_ext;
            a_q     <= '0;
            xneg1_q <= 1'b0;
        end else if (step) begin
            a_q     <= {a_pre[WIDTH], a_pre[WIDTH:1]};
            x_q     <= {a_pre[0], x_q[WIDTH:1]};
            xneg1_q <= x_q[0];
        end
    end

    // Signed runs stop one shift short, leaving the unconsumed sign bit in x_q[0].
    assign product = mode_q ? {a_q[WIDTH-1:0], x_q[WIDTH:1]}
                            : {a_q[WIDTH-2:0], x_q};

    always_comb begin
        out_bus = '0;
        if (show_hi)
            out_bus = product[2*WIDTH-1:WIDTH];
        else if (show_lo)
            out_bus = product[WIDTH-1:0];
    end

    assign mode = mode_q;

endmodule

// File: rtl/booth_mult_param.sv
// Sequential radix-2 Booth multiplier with a narrow shared bus: operands in
// over two cycles, product out as high then low half.
module booth_mult_param
    import booth_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] inBus,
    output logic [WIDTH-1:0] outBus,
    output logic             done,
    output logic             hi_sel,
    output logic             busy,
    output booth_state_t     dbg_state
);

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_width_check
        $error("booth_mult_param: WIDTH out of legal range");
    end

    booth_state_t     state;
    booth_state_t     next_state;
    logic [CNT_W-1:0] cnt;
    logic             mode;
    logic             cap_y;
    logic             cap_x;
    logic             step;
    logic             show_hi;
    logic             show_lo;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt <= '0;
        else if (state == LOAD_X)
            cnt <= iter_count(WIDTH, mode);
        else if (state == COMPUTE)
            cnt <= cnt - CNT_W'(1);
    end

    // start is only looked at in IDLE, so requests while busy are dropped.
    always_comb begin
        next_state = state;
        cap_y      = 1'b0;
        cap_x      = 1'b0;
        step       = 1'b0;
        show_hi    = 1'b0;
        show_lo    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    cap_y      = 1'b1;
                    next_state = LOAD_X;
                end
            end
            LOAD_X: begin
                cap_x      = 1'b1;
                next_state = COMPUTE;
            end
            COMPUTE: begin
                step = 1'b1;
                if (cnt == CNT_W'(1))
                    next_state = OUT_HI;
            end
            OUT_HI: begin
                show_hi    = 1'b1;
                next_state = OUT_LO;
            end
            OUT_LO: begin
                show_lo    = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    assign done      = show_hi | show_lo;
    assign hi_sel    = show_hi;
    assign busy      = (state != IDLE);
    assign dbg_state = state;

    booth_dp #(
        .WIDTH(WIDTH)
    ) u_dp (
        .clk        (clk),
        .rst        (rst),
        .cap_y      (cap_y),
        .cap_x      (cap_x),
        .step       (step),
        .show_hi    (show_hi),
        .show_lo    (show_lo),
        .signed_mode(signed_mode),
        .in_bus     (inBus),
        .mode       (mode),
        .out_bus    (outBus)
    );

endmodule

// File: tb/tb_booth_mult_param.sv
// Bench for booth_mult_param at WIDTH=8: directed corner cases, reset abort,
// held start and randomized back-to-back operations against an arithmetic model.
module tb_booth_mult_param;
    import booth_pkg::*;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic         signed_mode;
    logic [W-1:0] inBus;
    logic [W-1:0] outBus;
    logic         done;
    logic         hi_sel;
    logic         busy;
    booth_state_t dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    booth_mult_param #(
        .WIDTH(W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .signed_mode(signed_mode),
        .inBus      (inBus),
        .outBus     (outBus),
        .done       (done),
        .hi_sel     (hi_sel),
        .busy       (busy),
        .dbg_state  (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Full-precision product of the operands as the mode interprets them.
    function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic smode);
        longint va, vb, p;
        va = smode ? longint'($signed(a)) : longint'(a);
        vb = smode ? longint'($signed(b)) : longint'(b);
        p  = va * vb;
        return p[2*W-1:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called in an IDLE cycle; returns in the IDLE cycle following OUT_LO.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic smode, input bit hold);
        logic [2*W-1:0] exp;
        int k;
        int c;
        bit quiet_ok;
        exp      = model(a, b, smode);
        k        = smode ? W : W + 1;
        quiet_ok = 1'b1;
        start       = 1'b1;
        signed_mode = smode;
        inBus       = a;
        tick();
        c           = 1;
        inBus       = b;
        signed_mode = 1'($urandom);
        start       = hold;
        while (done !== 1'b1 && c < 60) begin
            if (busy !== 1'b1 || outBus !== '0) quiet_ok = 1'b0;
            tick();
            c++;
            inBus       = W'($urandom);
            signed_mode = 1'($urandom);
            if (!hold) start = 1'($urandom_range(0, 1));
        end
        start = hold;
        check("busy_quiet_window", 64'(quiet_ok), 64'd1);
        check("hi_latency", 64'(c), 64'(k + 2));
        check("hi_sel_on_hi", 64'(hi_sel), 64'd1);
        check("product_hi", 64'(outBus), 64'(exp[2*W-1:W]));
        tick();
        check("done_on_lo", 64'(done), 64'd1);
        check("hi_sel_on_lo", 64'(hi_sel), 64'd0);
        check("product_lo", 64'(outBus), 64'(exp[W-1:0]));
        tick();
        check("idle_after_lo", 64'({busy, done, hi_sel}), 64'd0);
        check("idle_outbus", 64'(outBus), 64'd0);
    endtask

    initial begin
        logic [W-1:0] corner[6];
        logic [W-1:0] a;
        logic [W-1:0] b;
        corner = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFF, 8'hFE};

        rst         = 1'b0;
        start       = 1'b0;
        signed_mode = 1'b0;
        inBus       = '0;
        #2;
        check("reset_outputs", 64'({busy, done, hi_sel}), 64'd0);
        check("reset_outbus", 64'(outBus), 64'd0);
        check("reset_state", 64'(dbg_state), 64'(IDLE));
        @(negedge clk);
        rst = 1'b1;
        tick();
        tick();
        check("idle_no_start", 64'(busy), 64'd0);

        run_op(8'h05, 8'hFD, 1'b1, 1'b0);
        run_op(8'h80, 8'h80, 1'b1, 1'b0);
        run_op(8'hFF, 8'hFF, 1'b0, 1'b0);
        run_op(8'h80, 8'h7F, 1'b1, 1'b0);
        run_op(8'h80, 8'hFF, 1'b0, 1'b0);

        // start held high across the whole run: only one operation until IDLE.
        run_op(8'h00, 8'h7F, 1'b1, 1'b1);
        tick();
        check("restart_from_idle", 64'(dbg_state), 64'(LOAD_X));
        start = 1'b0;
        rst   = 1'b0;
        #1;
        check("abort_idle", 64'(dbg_state), 64'(IDLE));
        @(negedge clk);
        rst = 1'b1;
        tick();

        // Abort during the 4th COMPUTE cycle.
        start       = 1'b1;
        signed_mode = 1'b1;
        inBus       = 8'h33;
        tick();
        inBus = 8'h44;
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("mid_compute_state", 64'(dbg_state), 64'(COMPUTE));
        rst = 1'b0;
        #1;
        check("reset_busy_now", 64'({busy, done, hi_sel}), 64'd0);
        check("reset_outbus_now", 64'(outBus), 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("reset_hold_quiet", 64'({busy, done}), 64'd0);
        end
        @(negedge clk);
        rst = 1'b1;
        tick();
        check("after_release_idle", 64'({busy, done}), 64'd0);
        run_op(8'h07, 8'h06, 1'b1, 1'b0);

        for (int i = 0; i < 24; i++) begin
            a = (($urandom_range(0, 3) == 0)) ? corner[$urandom_range(0, 5)] : W'($urandom);
            b = (($urandom_range(0, 3) == 0)) ? corner[$urandom_range(0, 5)] : W'($urandom);
            run_op(a, b, 1'($urandom_range(0, 1)), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/booth_mult_param.md
BOOTH_MULT_PARAM -- requirements
Module: booth_mult_param

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the operand and bus width; legal range 4..32.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 start  input  1  SHALL request a new multiplication; sampled only in IDLE.
REQ-005 signed_mode  input  1  SHALL select two's-complement (1) or unsigned (0) operands; sampled with start.
REQ-006 inBus  input  WIDTH  SHALL carry the multiplicand, then the multiplier, on consecutive cycles.
REQ-007 outBus  output  WIDTH  SHALL carry the product high half, then low half; 0 when not presenting.
REQ-008 done  output  1  SHALL be high only while outBus presents a product half.
REQ-009 hi_sel  output  1  SHALL be high while outBus carries the high half.
REQ-010 busy  output  1  SHALL be high in every state except IDLE.

Function
REQ-011 States SHALL be IDLE, LOAD_X, COMPUTE, OUT_HI, OUT_LO.
REQ-012 IDLE with start=1 SHALL capture inBus as Y and capture signed_mode, then go to LOAD_X; IDLE with start=0 SHALL stay in IDLE.
REQ-013 LOAD_X SHALL capture inBus as X, clear accumulator A, clear xneg1, load the iteration counter with K, and go to COMPUTE.
REQ-014 K SHALL be WIDTH in signed mode and WIDTH+1 in unsigned mode.
REQ-015 Internal operands SHALL be WIDTH+1 bits: sign-extended in signed mode, zero-extended in unsigned mode.
REQ-016 A SHALL be WIDTH+1 bits so that negating the most negative operand does not overflow.
REQ-017 Each COMPUTE cycle SHALL apply the radix-2 Booth rule on {x0,xneg1}: 01 A+=Y; 10 A-=Y; 00/11 no change.
REQ-018 Each COMPUTE cycle SHALL then arithmetic-shift {A,X,xneg1} right by one bit and decrement the counter.
REQ-019 After K COMPUTE cycles the FSM SHALL go to OUT_HI.
REQ-020 The 2*WIDTH-bit product SHALL be the low 2*WIDTH bits of the final {A,X}, exact for all operand pairs in both modes.
REQ-021 OUT_HI SHALL drive product[2W-1:W] with done=1 and hi_sel=1 for exactly one cycle, then go to OUT_LO.
REQ-022 OUT_LO SHALL drive product[W-1:0] with done=1 and hi_sel=0 for exactly one cycle, then go to IDLE.
REQ-023 Latency SHALL be fixed: the OUT_HI cycle SHALL begin K+2 cycles after the start cycle; total occupancy SHALL be K+4 cycles.
REQ-024 start asserted while busy SHALL be ignored and SHALL NOT be queued.
REQ-025 start may be asserted in the cycle immediately after OUT_LO (IDLE), allowing back-to-back operations with no dead cycle beyond IDLE.
REQ-026 inBus and signed_mode SHALL be ignored except in the sampling cycles named in REQ-012 and REQ-013.

Reset
REQ-027 rst low SHALL immediately force IDLE, busy=0, done=0, hi_sel=0, outBus=0, and clear A, X, Y, xneg1, counter and the captured mode.
REQ-028 rst asserted mid-operation SHALL abandon the operation with no output; the first start after release SHALL begin a fresh operation.

Structure
REQ-029 The FSM state encoding and the WIDTH legal-range constants SHALL reside in a shared package booth_pkg.
REQ-030 The design SHALL be split into a datapath sub-module booth_dp (registers, add/sub, shifter, output mux) and an in-module controller.
REQ-031 The datapath SHALL contain one WIDTH+1-bit adder/subtractor, shared between the add and subtract cases.

Verification (WIDTH=8)
REQ-032 Signed 5 x -3 (inBus 0x05 then 0xFD) -> OUT_HI 0xFF at cycle 10, OUT_LO 0xF1 at cycle 11.
REQ-033 Signed -128 x -128 (0x80, 0x80) -> outputs 0x40 then 0x00.
REQ-034 Unsigned 255 x 255 (0xFF, 0xFF) -> outputs 0xFE then 0x01, with OUT_HI at cycle 11 (K=9).
REQ-035 Signed 0 x 0x7F, with start held high throughout -> outputs 0x00, 0x00; no second operation begins until IDLE.
REQ-036 rst pulsed low during the 4th COMPUTE cycle -> done stays 0 and busy=0 immediately; a following signed 7 x 6 run -> outputs 0x00, 0x2A.
